// File: rtl/arbiter_types.sv
// Types shared by the cache arbiter and anything that observes its state.
package arbiter_types;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

  // Byte-offset bits within a 32-byte cacheline.
  localparam int LINE_OFFSET_W = 5;
endpackage

// File: rtl/rv32i_types.sv
// Core-wide shared types for the RV32I pipeline and its memory hierarchy.
package rv32i_types;
  typedef logic [31:0]  rv32i_word;
  typedef logic [255:0] cacheline_t;
endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing the physical-memory line port between the I-cache and D-cache.
// Requests are latched on grant so the memory side sees stable values for the whole transaction.
module cache_arbiter
  import rv32i_types::*;
  import arbiter_types::*;
#(
  parameter int LINE_W = $bits(cacheline_t),
  parameter int ADDR_W = $bits(rv32i_word)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << LINE_OFFSET_W;

  arb_state_t        state_reg, state_next;
  arb_grant_t        grant_reg, grant_next;
  arb_grant_t        last_grant_reg, last_grant_next;
  logic              grant_fire;
  logic              busy;
  logic              i_req, d_req;
  logic [ADDR_W-1:0] addr_reg;
  logic              write_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic [LINE_W-1:0] line_buf_reg;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  assign busy  = (state_reg == ARB_I) || (state_reg == ARB_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      grant_reg      <= GRANT_I;
      last_grant_reg <= GRANT_I;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // last_grant only moves on a genuine tie, so consecutive ties alternate winners.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    grant_fire      = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          grant_fire = 1'b1;
          if (i_req && d_req) begin
            grant_next      = (last_grant_reg == GRANT_I) ? GRANT_D : GRANT_I;
            last_grant_next = grant_next;
          end else begin
            grant_next = i_req ? GRANT_I : GRANT_D;
          end
          state_next = (grant_next == GRANT_I) ? ARB_I : ARB_D;
        end
      end
      ARB_I, ARB_D: begin
        if (pmem_resp) state_next = ARB_DONE;
      end
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // A D request with both read and write set is treated as a writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      wdata_reg    <= '0;
      line_buf_reg <= '0;
    end else begin
      if (grant_fire) begin
        if (grant_next == GRANT_I) begin
          addr_reg  <= i_pmem_address & ALIGN_MASK;
          write_reg <= 1'b0;
        end else begin
          addr_reg  <= d_pmem_address & ALIGN_MASK;
          write_reg <= d_pmem_write;
          if (d_pmem_write) wdata_reg <= d_pmem_wdata;
        end
      end
      if (busy && pmem_resp && !write_reg) line_buf_reg <= pmem_rdata;
    end
  end

  always_comb begin
    pmem_read    = busy & ~write_reg;
    pmem_write   = busy & write_reg;
    pmem_address = addr_reg;
    pmem_wdata   = wdata_reg;
    i_pmem_resp  = (state_reg == ARB_DONE) && (grant_reg == GRANT_I);
    d_pmem_resp  = (state_reg == ARB_DONE) && (grant_reg == GRANT_D);
    i_pmem_rdata = line_buf_reg;
    d_pmem_rdata = line_buf_reg;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: a small memory responder plus hand-computed expectations.
module tb_cache_arbiter;
  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [31:0]  i_pmem_address;
  logic [255:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [31:0]  d_pmem_address;
  logic [255:0] d_pmem_wdata;
  logic [255:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;
  int violations = 0;

  // Per-transaction observations recorded by serve().
  int           tx_wait, tx_strobes;
  logic [31:0]  tx_addr;
  logic         tx_write, tx_saw_read, tx_stable;
  logic [255:0] tx_wdata, tx_rdata;
  logic         tx_i_resp, tx_d_resp, tx_strobe_after, tx_resp_after, tx_same_rdata;
  logic         resp_acc;

  localparam logic [255:0] LINE_AA = {8{32'hAAAAAAAA}};
  localparam logic [255:0] LINE_55 = {8{32'h55555555}};
  localparam logic [255:0] LINE_5A = {8{32'h5A5A5A5A}};
  localparam logic [255:0] LINE_77 = {8{32'h77777777}};
  localparam logic [255:0] PAT_W1  = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210,
                                      32'h0F0F0F0F, 32'hF0F0F0F0, 32'h13572468, 32'h24681357};
  localparam logic [255:0] PAT_W2  = {8{32'hC0FFEE11}};
  localparam logic [255:0] PAT_W3  = {8{32'h3C3C00FF}};

  cache_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: a D-cache request may not be both read and write.
  always @(posedge clk) begin
    if (!rst && d_pmem_read && d_pmem_write) begin
      violations <= violations + 1;
      $display("protocol violation: d_pmem_read and d_pmem_write both high at %0t", $time);
    end
  end

  task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as memory: waits for a strobe, answers after lat strobe cycles, then
  // observes the response cycle and drops the served request there.
  task automatic serve(input int lat, input logic [255:0] line, input bit perturb);
    int n;
    n = 0;
    tx_saw_read = 0; tx_strobes = 0; tx_stable = 1; tx_i_resp = 0; tx_d_resp = 0;
    tx_rdata = '0; tx_addr = '0; tx_write = 0; tx_wdata = '0;
    tx_resp_after = 0; tx_strobe_after = 0; tx_same_rdata = 0;
    while (!(pmem_read || pmem_write) && n < 20) begin
      tick();
      n++;
    end
    tx_wait = n;
    if (!(pmem_read || pmem_write)) begin
      check_value("strobe_timeout", pmem_read | pmem_write, 1);
      i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
      return;
    end
    tx_addr  = pmem_address;
    tx_write = pmem_write;
    tx_wdata = pmem_wdata;
    for (int k = 1; k <= lat; k++) begin
      if (pmem_read || pmem_write) tx_strobes++;
      if (pmem_read) tx_saw_read = 1;
      if (pmem_address !== tx_addr || pmem_wdata !== tx_wdata || pmem_write !== tx_write)
        tx_stable = 0;
      if (perturb && k == 2) begin
        d_pmem_address = ~d_pmem_address;
        d_pmem_wdata   = ~d_pmem_wdata;
      end
      if (k == lat) begin
        pmem_resp  = 1;
        pmem_rdata = line;
      end
      tick();
    end
    pmem_resp  = 0;
    pmem_rdata = {8{32'hDEADBEEF}};
    tx_strobe_after = pmem_read | pmem_write;
    tx_i_resp       = i_pmem_resp;
    tx_d_resp       = d_pmem_resp;
    tx_rdata        = i_pmem_resp ? i_pmem_rdata : d_pmem_rdata;
    tx_same_rdata   = (i_pmem_rdata === d_pmem_rdata);
    if (i_pmem_resp) i_pmem_read = 0;
    if (d_pmem_resp) begin
      d_pmem_read  = 0;
      d_pmem_write = 0;
    end
    tick();
    tx_resp_after = i_pmem_resp | d_pmem_resp;
    $display("tx addr=%h write=%0d wait=%0d strobes=%0d i_resp=%0d d_resp=%0d rdata=%h",
             tx_addr, tx_write, tx_wait, tx_strobes, tx_i_resp, tx_d_resp, tx_rdata[31:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; i_pmem_read = 0; i_pmem_address = '0; d_pmem_read = 0; d_pmem_write = 0;
    d_pmem_address = '0; d_pmem_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
    repeat (2) tick();

    check_value("rst_pmem_read", pmem_read, 0);
    check_value("rst_pmem_write", pmem_write, 0);
    check_value("rst_i_resp", i_pmem_resp, 0);
    check_value("rst_d_resp", d_pmem_resp, 0);
    check_value("rst_address", pmem_address, 0);
    check_value("rst_wdata", pmem_wdata, 0);
    check_value("rst_i_rdata", i_pmem_rdata, 0);
    check_value("rst_d_rdata", d_pmem_rdata, 0);
    rst = 0;
    tick();

    // Lone I read, 5-cycle memory latency.
    i_pmem_read = 1; i_pmem_address = 32'h0000_1234;
    serve(5, LINE_AA, 0);
    check_value("i_latency", tx_wait, 1);
    check_value("i_address", tx_addr, 32'h0000_1220);
    check_value("i_is_read", tx_saw_read, 1);
    check_value("i_strobes", tx_strobes, 5);
    check_value("i_strobe_drop", tx_strobe_after, 0);
    check_value("i_resp", tx_i_resp, 1);
    check_value("i_no_d_resp", tx_d_resp, 0);
    check_value("i_rdata", tx_rdata, LINE_AA);
    check_value("i_shared_buf", tx_same_rdata, 1);
    check_value("i_resp_one_cycle", tx_resp_after, 0);

    // Spurious memory response while idle.
    pmem_resp = 1; pmem_rdata = LINE_77;
    tick();
    pmem_resp = 0;
    check_value("spur_no_resp", i_pmem_resp | d_pmem_resp, 0);
    check_value("spur_no_strobe", pmem_read | pmem_write, 0);
    check_value("spur_buf_kept", i_pmem_rdata, LINE_AA);

    // Lone D writeback; memory drives junk rdata that must not be captured.
    d_pmem_write = 1; d_pmem_address = 32'h8000_0040; d_pmem_wdata = PAT_W1;
    serve(3, LINE_55, 0);
    check_value("dw_address", tx_addr, 32'h8000_0040);
    check_value("dw_is_write", tx_write, 1);
    check_value("dw_no_read", tx_saw_read, 0);
    check_value("dw_wdata", tx_wdata, PAT_W1);
    check_value("dw_d_resp", tx_d_resp, 1);
    check_value("dw_no_i_resp", tx_i_resp, 0);
    check_value("dw_buf_kept", tx_rdata, LINE_AA);

    // Tie right after reset: D first, then I after a 2-cycle gap.
    i_pmem_read = 1; i_pmem_address = 32'h0000_2004;
    d_pmem_read = 1; d_pmem_address = 32'h0000_3008;
    serve(2, LINE_55, 0);
    check_value("tie1_first_addr", tx_addr, 32'h0000_3000);
    check_value("tie1_first_d", tx_d_resp, 1);
    check_value("tie1_first_rdata", tx_rdata, LINE_55);
    serve(2, LINE_5A, 0);
    check_value("tie1_gap", tx_wait, 1);
    check_value("tie1_second_addr", tx_addr, 32'h0000_2000);
    check_value("tie1_second_i", tx_i_resp, 1);
    check_value("tie1_second_rdata", tx_rdata, LINE_5A);

    // Second tie alternates: I first.
    i_pmem_read = 1; i_pmem_address = 32'h0000_4010;
    d_pmem_read = 1; d_pmem_address = 32'h0000_5020;
    serve(2, LINE_AA, 0);
    check_value("tie2_first_addr", tx_addr, 32'h0000_4000);
    check_value("tie2_first_i", tx_i_resp, 1);
    serve(2, LINE_55, 0);
    check_value("tie2_second_addr", tx_addr, 32'h0000_5020);
    check_value("tie2_second_d", tx_d_resp, 1);

    // D inputs change mid-transaction; latched values must hold.
    d_pmem_write = 1; d_pmem_address = 32'h0000_6000; d_pmem_wdata = PAT_W2;
    serve(4, LINE_77, 1);
    check_value("hold_stable", tx_stable, 1);
    check_value("hold_address", tx_addr, 32'h0000_6000);
    check_value("hold_wdata", pmem_wdata, PAT_W2);
    check_value("hold_d_resp", tx_d_resp, 1);

    // Asynchronous reset during an I read.
    i_pmem_read = 1; i_pmem_address = 32'h0000_9000;
    tick();
    check_value("rmid_strobe_up", pmem_read, 1);
    tick();
    #2;
    rst = 1;
    #1;
    check_value("rmid_read_drop", pmem_read, 0);
    check_value("rmid_addr_clear", pmem_address, 0);
    i_pmem_read = 0;
    resp_acc = 0;
    pmem_resp = 1; pmem_rdata = LINE_77;
    for (int k = 0; k < 3; k++) begin
      tick();
      resp_acc = resp_acc | i_pmem_resp | d_pmem_resp;
      pmem_resp = 0;
    end
    rst = 0;
    tick();
    resp_acc = resp_acc | i_pmem_resp | d_pmem_resp;
    check_value("rmid_no_resp", resp_acc, 0);
    check_value("rmid_buf_clear", i_pmem_rdata, 0);
    i_pmem_read = 1; i_pmem_address = 32'h0000_A01F;
    serve(2, LINE_5A, 0);
    check_value("rmid_fresh_latency", tx_wait, 1);
    check_value("rmid_fresh_addr", tx_addr, 32'h0000_A000);
    check_value("rmid_fresh_resp", tx_i_resp, 1);
    check_value("rmid_fresh_rdata", tx_rdata, LINE_5A);

    // Illegal D request: write must win and the monitor must flag it.
    check_value("illegal_none_yet", violations, 0);
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 32'h0000_C000; d_pmem_wdata = PAT_W3;
    serve(3, LINE_77, 0);
    check_value("illegal_is_write", tx_write, 1);
    check_value("illegal_no_read", tx_saw_read, 0);
    check_value("illegal_wdata", tx_wdata, PAT_W3);
    check_value("illegal_d_resp", tx_d_resp, 1);
    check_value("illegal_flagged", violations != 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
